// File: rtl/uart_tx_serializer.sv
// UART TX datapath: latches byte and parity at load, shifts one bit per CLK under ser_en,
// and registers the 4:1 line mux onto TX_OUT. Define UART_TX_MSB_FIRST_EN for MSB-first data.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  busy,
    input  logic                  PAR_TYP,
    input  logic                  ser_en,
    input  logic [1:0]            mux_sel,
    output logic                  ser_done,
    output logic                  TX_OUT
);

    localparam logic [CNT_WIDTH-1:0] LAST_BIT   = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [1:0]           LINE_START = 2'b00;
    localparam logic [1:0]           LINE_STOP  = 2'b01;
    localparam logic [1:0]           LINE_DATA  = 2'b10;
    localparam logic [1:0]           LINE_PAR   = 2'b11;

    logic [DATA_WIDTH-1:0] r_shift_reg;
    logic [CNT_WIDTH-1:0]  r_bit_cnt;
    logic                  r_par_bit;
    logic                  r_loaded;

    logic                  w_load;
    logic                  w_at_last;
    logic                  w_shift;
    logic                  w_frame_end;
    logic                  w_ser_data;
    logic                  w_line;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    assign w_load    = Data_Valid & ~busy;
    assign w_at_last = (r_bit_cnt == LAST_BIT);
    // Counter saturates on the last bit, so a stray ser_en cannot wrap the frame.
    assign w_shift   = ser_en & ~w_load & ~w_at_last;
    assign ser_done  = r_loaded & w_at_last;
    // ser_done holds through parity/stop, so the stop cycle always finds it set.
    assign w_frame_end = (mux_sel == LINE_STOP) & ser_done & ~w_load;

`ifdef UART_TX_MSB_FIRST_EN
    assign w_ser_data  = r_shift_reg[DATA_WIDTH-1];
    assign w_shift_nxt = {r_shift_reg[DATA_WIDTH-2:0], 1'b0};
`else
    assign w_ser_data  = r_shift_reg[0];
    assign w_shift_nxt = {1'b0, r_shift_reg[DATA_WIDTH-1:1]};
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
            r_par_bit   <= 1'b0;
            r_loaded    <= 1'b0;
        end else if (w_load) begin
            r_shift_reg <= P_DATA;
            r_bit_cnt   <= '0;
            r_par_bit   <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            r_loaded    <= 1'b1;
        end else if (w_shift) begin
            r_shift_reg <= w_shift_nxt;
            r_bit_cnt   <= r_bit_cnt + CNT_WIDTH'(1);
        end else if (w_frame_end) begin
            r_bit_cnt   <= '0;
            r_loaded    <= 1'b0;
        end
    end

    always_comb begin
        w_line = 1'b1;
        case (mux_sel)
            LINE_START: w_line = 1'b0;
            LINE_STOP:  w_line = 1'b1;
            LINE_DATA:  w_line = w_ser_data;
            LINE_PAR:   w_line = r_par_bit;
            default:    w_line = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) TX_OUT <= 1'b1;
        else      TX_OUT <= w_line;
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: emulates the TX FSM per frame and compares TX_OUT/ser_done
// against a frame model built from the line protocol (start, data, optional parity, stop).
module tb_uart_tx_serializer;
    localparam int DW = 8;
`ifdef UART_TX_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic          CLK, RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid, busy, PAR_TYP, ser_en;
    logic [1:0]    mux_sel;
    logic          ser_done, TX_OUT;

    int vectors = 0;
    int miscompares = 0;

    logic obs_tx[0:15], obs_done[0:15], exp_tx[0:15], exp_done[0:15];
    int   obs_n, exp_n;

    uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .busy(busy),
        .PAR_TYP(PAR_TYP), .ser_en(ser_en), .mux_sel(mux_sel), .ser_done(ser_done), .TX_OUT(TX_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: what the line must carry and when ser_done must be up, from frame rules alone.
    task automatic build_expect(input logic [DW-1:0] d, input bit pty, input bit pen, input bit stray);
        int nd, kk;
        nd = DW + (stray ? 1 : 0);
        exp_n = 2 + nd + (pen ? 1 : 0) + 1;
        exp_tx[0] = 1'b1;  exp_tx[1] = 1'b1;  exp_tx[2] = 1'b0;
        exp_done[0] = 1'b0; exp_done[1] = 1'b0;
        for (int k = 0; k < nd; k++) begin
            kk = (k > DW - 1) ? DW - 1 : k;
            exp_tx[3 + k]   = MSB ? d[DW - 1 - kk] : d[kk];
            exp_done[2 + k] = (k >= DW - 1);
        end
        if (pen) begin
            exp_tx[3 + nd]   = 1'(($countones(d) % 2) != 0) ^ pty;
            exp_done[2 + nd] = 1'b1;
        end
        exp_tx[exp_n]       = 1'b1;
        exp_done[exp_n - 1] = 1'b1;
    endtask

    // FSM emulation: idle(load), start, data, [parity], stop; records outputs at each cycle start.
    task automatic drive_frame(input logic [DW-1:0] d, input bit pty, input bit pen, input bit hold_dv,
                               input bit flip, input bit inject, input bit stray);
        int nd, n, k;
        nd = DW + (stray ? 1 : 0);
        n  = 2 + nd + (pen ? 1 : 0) + 1;
        for (int j = 0; j < n; j++) begin
            @(posedge CLK); #1;
            obs_tx[j] = TX_OUT; obs_done[j] = ser_done;
            if (j == 0) begin
                mux_sel = 2'b01; busy = 1'b0; Data_Valid = 1'b1; P_DATA = d; PAR_TYP = pty; ser_en = 1'b0;
            end else if (j == 1) begin
                mux_sel = 2'b00; busy = 1'b0; Data_Valid = hold_dv; ser_en = 1'b0;
            end else if (j < 2 + nd) begin
                k = j - 2;
                mux_sel = 2'b10; busy = 1'b1; Data_Valid = inject;
                ser_en  = (k < DW - 1) || (stray && k == DW - 1);
                P_DATA  = inject ? DW'(8'h3C) : DW'($urandom);
                if (flip) PAR_TYP = ~pty;
            end else if (pen && j == 2 + nd) begin
                mux_sel = 2'b11; busy = 1'b1; Data_Valid = inject; ser_en = 1'b0;
            end else begin
                mux_sel = 2'b01; busy = 1'b1; Data_Valid = 1'b0; ser_en = 1'b0;
            end
        end
        @(posedge CLK); #1;
        obs_tx[n] = TX_OUT; obs_n = n;
        mux_sel = 2'b01; busy = 1'b0; Data_Valid = 1'b0; ser_en = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0; busy = 1'b0; PAR_TYP = 1'b0; ser_en = 1'b0;
        mux_sel = 2'b00;
        #3 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if (TX_OUT !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b expected 1", TX_OUT); end
        vectors++;
        if (ser_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", ser_done); end
        mux_sel = 2'b01;
        #2 RST = 1'b1;
    endtask

    task automatic test_parity_frames;
        logic [DW-1:0] d;
        bit pty;
        for (int t = 0; t < 3; t++) begin
            d   = (t == 0) ? DW'(8'hA5) : DW'(8'h01);
            pty = (t == 1);
            drive_frame(d, pty, 1'b1, 1'b1, (t != 0), 1'b0, 1'b0);
            build_expect(d, pty, 1'b1, 1'b0);
            for (int j = 0; j <= obs_n; j++) begin
                vectors++;
                if (obs_tx[j] !== exp_tx[j]) begin
                    miscompares++;
                    $display("FAIL parity_frame%0d tx[%0d] got %b expected %b", t, j, obs_tx[j], exp_tx[j]);
                end
                if (j < obs_n) begin
                    vectors++;
                    if (obs_done[j] !== exp_done[j]) begin
                        miscompares++;
                        $display("FAIL parity_frame%0d done[%0d] got %b expected %b", t, j, obs_done[j], exp_done[j]);
                    end
                end
            end
            vectors++;
            if (t > 0 && obs_tx[3 + DW] !== (t == 1 ? 1'b0 : 1'b1)) begin
                miscompares++;
                $display("FAIL parity_0x01_typ%0d got %b expected %b", pty, obs_tx[3 + DW], (t == 1 ? 1'b0 : 1'b1));
            end
        end
    endtask

    task automatic test_no_parity;
        logic [DW-1:0] d;
        for (int t = 0; t < 2; t++) begin
            d = (t == 0) ? DW'(8'hFF) : DW'($urandom);
            drive_frame(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (t == 1));
            build_expect(d, 1'b0, 1'b0, (t == 1));
            for (int j = 0; j <= obs_n; j++) begin
                vectors++;
                if (obs_tx[j] !== exp_tx[j]) begin
                    miscompares++;
                    $display("FAIL noparity%0d tx[%0d] got %b expected %b", t, j, obs_tx[j], exp_tx[j]);
                end
                if (j < obs_n) begin
                    vectors++;
                    if (obs_done[j] !== exp_done[j]) begin
                        miscompares++;
                        $display("FAIL noparity%0d done[%0d] got %b expected %b", t, j, obs_done[j], exp_done[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] d;
        for (int t = 0; t < 2; t++) begin
            d = (t == 0) ? DW'($urandom) : DW'(8'h3C);
            drive_frame(d, 1'b1, 1'b1, 1'b0, 1'b0, (t == 0), 1'b0);
            build_expect(d, 1'b1, 1'b1, 1'b0);
            for (int j = 0; j <= obs_n; j++) begin
                vectors++;
                if (obs_tx[j] !== exp_tx[j]) begin
                    miscompares++;
                    $display("FAIL b2b%0d tx[%0d] got %b expected %b", t, j, obs_tx[j], exp_tx[j]);
                end
                if (j < obs_n) begin
                    vectors++;
                    if (obs_done[j] !== exp_done[j]) begin
                        miscompares++;
                        $display("FAIL b2b%0d done[%0d] got %b expected %b", t, j, obs_done[j], exp_done[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [DW-1:0] d;
        @(posedge CLK); #1;
        mux_sel = 2'b01; busy = 1'b0; Data_Valid = 1'b1; P_DATA = '0; PAR_TYP = 1'b0; ser_en = 1'b0;
        @(posedge CLK); #1;
        mux_sel = 2'b00; Data_Valid = 1'b0;
        @(posedge CLK); #1;
        mux_sel = 2'b10; busy = 1'b1; ser_en = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        vectors++;
        if (TX_OUT !== 1'b0) begin miscompares++; $display("FAIL midrst_pre got %b expected 0", TX_OUT); end
        #2 RST = 1'b0;
        #1;
        vectors++;
        if (TX_OUT !== 1'b1) begin miscompares++; $display("FAIL midrst_tx got %b expected 1", TX_OUT); end
        vectors++;
        if (ser_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b expected 0", ser_done); end
        mux_sel = 2'b01; busy = 1'b0; ser_en = 1'b0; Data_Valid = 1'b0;
        #1 RST = 1'b1;
        d = DW'($urandom);
        drive_frame(d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        build_expect(d, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j <= obs_n; j++) begin
            vectors++;
            if (obs_tx[j] !== exp_tx[j]) begin
                miscompares++;
                $display("FAIL midrst_frame tx[%0d] got %b expected %b", j, obs_tx[j], exp_tx[j]);
            end
            if (j < obs_n) begin
                vectors++;
                if (obs_done[j] !== exp_done[j]) begin
                    miscompares++;
                    $display("FAIL midrst_frame done[%0d] got %b expected %b", j, obs_done[j], exp_done[j]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] d;
        bit pty, pen, hold, flip, inj;
        for (int t = 0; t < 10; t++) begin
            d = DW'($urandom);
            pty = 1'($urandom); pen = 1'($urandom); hold = 1'($urandom);
            flip = 1'($urandom); inj = 1'($urandom);
            drive_frame(d, pty, pen, hold, flip, inj, 1'b0);
            build_expect(d, pty, pen, 1'b0);
            for (int j = 0; j <= obs_n; j++) begin
                vectors++;
                if (obs_tx[j] !== exp_tx[j]) begin
                    miscompares++;
                    $display("FAIL rand%0d d=%h tx[%0d] got %b expected %b", t, d, j, obs_tx[j], exp_tx[j]);
                end
                if (j < obs_n) begin
                    vectors++;
                    if (obs_done[j] !== exp_done[j]) begin
                        miscompares++;
                        $display("FAIL rand%0d d=%h done[%0d] got %b expected %b", t, d, j, obs_done[j], exp_done[j]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_parity_frames();
        test_no_parity();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
